conv_layer_sched: RTL and testbench

Layer sequencer for the conv engine. On `layer_start` it walks the tile loops (oc → ic → h → w) for the programmed layer shape. For each step it issues weight-buffer and input-loader requests with req/ack handshakes, then enables the dataflow and counts PE-array valid beats. It drives the loop indices and buffer selects observed by the utilization monitor, and pulses `layer_done` once the layer completes. It supports row-based and frame-based dataflow.

---
 rtl/conv_layer_sched_if.sv | 25 ++
 rtl/conv_layer_sched.sv | 208 ++++++++++++++++++++
 tb/tb_conv_layer_sched.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_layer_sched_if.sv
// conv_layer_sched_if: request/acknowledge and dataflow signals between the layer
// sequencer and the conv engine datapath.
//   master (sequencer): drives weight_req, input_loader_req, dataflow_en;
//                       receives weight_ack, input_loader_ack, conv_vld.
//   slave  (datapath):  the mirror image.
interface conv_layer_sched_if #(
  parameter int unsigned NUM_PE = 9
);
  logic              weight_req;
  logic              weight_ack;
  logic              input_loader_req;
  logic              input_loader_ack;
  logic              dataflow_en;
  logic [NUM_PE-1:0] conv_vld;

  modport master (
    output weight_req, input_loader_req, dataflow_en,
    input  weight_ack, input_loader_ack, conv_vld
  );

  modport slave (
    input  weight_req, input_loader_req, dataflow_en,
    output weight_ack, input_loader_ack, conv_vld
  );
endinterface

// File: rtl/conv_layer_sched.sv
// conv_layer_sched: walks the oc -> ic -> h -> w tile loops of one conv layer.
// Each step loads weights and inputs with req/ack handshakes, then enables the
// PE array and counts beats (cycles where every PE is valid).
// Ports:
//   clk, rstn                    clock, async active-low reset
//   layer_start, is_last_layer   start pulse and last-layer flag (sampled together)
//   cfg_frame, cfg_w/h/ic/oc     dataflow mode and tile counts (0 is treated as 1)
//   bus                          handshakes, dataflow_en and conv_vld
//   w/h/ic/oc_idx                current loop indices
//   weight_buf_sel, input_buff_sel  ping-pong selects, toggled per completed load
//   busy, layer_done, last_layer_done  status; the done signals are single pulses
// Every output is decoded from registered state only.
module conv_layer_sched #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned NUM_PE = 9
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               layer_start,
  input  logic               is_last_layer,
  input  logic               cfg_frame,
  input  logic [CNT_W-1:0]   cfg_w,
  input  logic [CNT_W-1:0]   cfg_h,
  input  logic [CNT_W-1:0]   cfg_ic,
  input  logic [CNT_W-1:0]   cfg_oc,
  conv_layer_sched_if.master bus,
  output logic [CNT_W-1:0]   w_idx,
  output logic [CNT_W-1:0]   h_idx,
  output logic [CNT_W-1:0]   ic_idx,
  output logic [CNT_W-1:0]   oc_idx,
  output logic               weight_buf_sel,
  output logic               input_buff_sel,
  output logic               busy,
  output logic               layer_done,
  output logic               last_layer_done
);
  localparam int unsigned PW = 2 * CNT_W;

  typedef enum logic [2:0] {StIdle, StWload, StIload, StCompute, StNext, StDone} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  w_q, w_d, h_q, h_d, ic_q, ic_d, oc_q, oc_d;
  logic [CNT_W-1:0]  cw_q, cw_d, ch_q, ch_d, cic_q, cic_d, coc_q, coc_d;
  logic [PW-1:0]     tgt_q, tgt_d, beat_q, beat_d;
  logic              wsel_q, wsel_d, isel_q, isel_d;
  logic              frame_q, frame_d, last_q, last_d;

  logic [CNT_W-1:0]  w_nz, h_nz, ic_nz, oc_nz;
  logic [CNT_W-1:0]  w_inc, h_inc, ic_inc, oc_inc;
  logic [PW-1:0]     beat_inc;
  logic [NUM_PE-1:0] vld;

  assign vld = bus.conv_vld;

  always_comb begin
    w_nz     = (cfg_w  == '0) ? CNT_W'(1) : cfg_w;
    h_nz     = (cfg_h  == '0) ? CNT_W'(1) : cfg_h;
    ic_nz    = (cfg_ic == '0) ? CNT_W'(1) : cfg_ic;
    oc_nz    = (cfg_oc == '0) ? CNT_W'(1) : cfg_oc;
    w_inc    = w_q  + CNT_W'(1);
    h_inc    = h_q  + CNT_W'(1);
    ic_inc   = ic_q + CNT_W'(1);
    oc_inc   = oc_q + CNT_W'(1);
    beat_inc = beat_q + PW'(1);

    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    ic_d    = ic_q;
    oc_d    = oc_q;
    cw_d    = cw_q;
    ch_d    = ch_q;
    cic_d   = cic_q;
    coc_d   = coc_q;
    tgt_d   = tgt_q;
    beat_d  = beat_q;
    wsel_d  = wsel_q;
    isel_d  = isel_q;
    frame_d = frame_q;
    last_d  = last_q;

    unique case (state_q)
      StIdle: begin
        if (layer_start) begin
          cw_d    = w_nz;
          ch_d    = h_nz;
          cic_d   = ic_nz;
          coc_d   = oc_nz;
          frame_d = cfg_frame;
          last_d  = is_last_layer;
          // Frame mode streams the whole W x H tile in one COMPUTE pass.
          tgt_d   = cfg_frame ? PW'(w_nz) * PW'(h_nz) : PW'(w_nz);
          w_d     = '0;
          h_d     = '0;
          ic_d    = '0;
          oc_d    = '0;
          beat_d  = '0;
          wsel_d  = 1'b0;
          isel_d  = 1'b0;
          state_d = StWload;
        end
      end
      StWload: begin
        if (bus.weight_ack) begin
          wsel_d  = ~wsel_q;
          state_d = StIload;
        end
      end
      StIload: begin
        if (bus.input_loader_ack) begin
          isel_d  = ~isel_q;
          state_d = StCompute;
        end
      end
      StCompute: begin
        if (&vld) begin
          beat_d = beat_inc;
          if (frame_q && (w_inc == cw_q)) begin
            w_d = '0;
            h_d = h_inc;
          end else begin
            w_d = w_inc;
          end
          if (beat_inc == tgt_q) state_d = StNext;
        end
      end
      StNext: begin
        w_d    = '0;
        beat_d = '0;
        if (!frame_q && (h_inc != ch_q)) begin
          h_d     = h_inc;
          state_d = StIload;
        end else begin
          // Row wrap or any frame pass: advance ic, reload weights.
          // The final pass leaves ic/oc (and row-mode h) on their last values.
          if (frame_q) h_d = '0;
          if (ic_inc != cic_q) begin
            if (!frame_q) h_d = '0;
            ic_d    = ic_inc;
            state_d = StWload;
          end else if (oc_inc != coc_q) begin
            h_d     = '0;
            ic_d    = '0;
            oc_d    = oc_inc;
            state_d = StWload;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      w_q     <= '0;
      h_q     <= '0;
      ic_q    <= '0;
      oc_q    <= '0;
      cw_q    <= '0;
      ch_q    <= '0;
      cic_q   <= '0;
      coc_q   <= '0;
      tgt_q   <= '0;
      beat_q  <= '0;
      wsel_q  <= 1'b0;
      isel_q  <= 1'b0;
      frame_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      ic_q    <= ic_d;
      oc_q    <= oc_d;
      cw_q    <= cw_d;
      ch_q    <= ch_d;
      cic_q   <= cic_d;
      coc_q   <= coc_d;
      tgt_q   <= tgt_d;
      beat_q  <= beat_d;
      wsel_q  <= wsel_d;
      isel_q  <= isel_d;
      frame_q <= frame_d;
      last_q  <= last_d;
    end
  end

  assign bus.weight_req       = (state_q == StWload);
  assign bus.input_loader_req = (state_q == StIload);
  assign bus.dataflow_en      = (state_q == StCompute);
  assign busy                 = (state_q != StIdle);
  assign layer_done           = (state_q == StDone);
  assign last_layer_done      = (state_q == StDone) && last_q;
  assign w_idx                = w_q;
  assign h_idx                = h_q;
  assign ic_idx               = ic_q;
  assign oc_idx               = oc_q;
  assign weight_buf_sel       = wsel_q;
  assign input_buff_sel       = isel_q;
endmodule

// File: tb/tb_conv_layer_sched.sv
module tb_conv_layer_sched;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned NUM_PE = 9;

  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             layer_start = 1'b0;
  logic             is_last_layer = 1'b0;
  logic             cfg_frame = 1'b0;
  logic [CNT_W-1:0] cfg_w = '0, cfg_h = '0, cfg_ic = '0, cfg_oc = '0;
  logic [CNT_W-1:0] w_idx, h_idx, ic_idx, oc_idx;
  logic             weight_buf_sel, input_buff_sel, busy, layer_done, last_layer_done;

  conv_layer_sched_if #(.NUM_PE(NUM_PE)) bus ();

  conv_layer_sched #(.CNT_W(CNT_W), .NUM_PE(NUM_PE)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .layer_start     (layer_start),
    .is_last_layer   (is_last_layer),
    .cfg_frame       (cfg_frame),
    .cfg_w           (cfg_w),
    .cfg_h           (cfg_h),
    .cfg_ic          (cfg_ic),
    .cfg_oc          (cfg_oc),
    .bus             (bus.master),
    .w_idx           (w_idx),
    .h_idx           (h_idx),
    .ic_idx          (ic_idx),
    .oc_idx          (oc_idx),
    .weight_buf_sel  (weight_buf_sel),
    .input_buff_sel  (input_buff_sel),
    .busy            (busy),
    .layer_done      (layer_done),
    .last_layer_done (last_layer_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Input driver: acks and conv_vld, changed 1 time unit after each rising edge.
  bit auto_drv = 1'b1;
  bit ack_rand = 1'b0;
  bit vld_rand = 1'b0;
  initial begin
    bus.weight_ack       = 1'b0;
    bus.input_loader_ack = 1'b0;
    bus.conv_vld         = '0;
    forever begin
      @(posedge clk);
      #1;
      if (auto_drv) begin
        bus.weight_ack       = ack_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
        bus.input_loader_ack = ack_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
        if (vld_rand && $urandom_range(0, 1) == 1) bus.conv_vld = NUM_PE'($urandom);
        else bus.conv_vld = '1;
      end
    end
  end

  // Monitor: summarises one layer run, sampled mid-cycle on the falling edge.
  int           cyc = 0;
  logic [63:0]  wreq_mask, ireq_mask, en_mask;
  int           n_wh, n_ih, n_wreq_hi, cur_beats, done_cnt, done_cyc, ld_cnt, ld_both;
  bit           prev_en = 1'b0;
  int           beats_q[$];
  logic [47:0]  ih_seq[$];

  always @(negedge clk) begin
    if (rstn && layer_start && !busy) begin
      cyc = 0;
      wreq_mask = '0; ireq_mask = '0; en_mask = '0;
      n_wh = 0; n_ih = 0; n_wreq_hi = 0; cur_beats = 0;
      done_cnt = 0; done_cyc = -1; ld_cnt = 0; ld_both = 0;
      beats_q.delete();
      ih_seq.delete();
    end else begin
      cyc++;
      if (cyc < 64) begin
        if (bus.weight_req)       wreq_mask[cyc[5:0]] = 1'b1;
        if (bus.input_loader_req) ireq_mask[cyc[5:0]] = 1'b1;
        if (bus.dataflow_en)      en_mask[cyc[5:0]]   = 1'b1;
      end
      if (bus.weight_req) n_wreq_hi++;
      if (bus.weight_req && bus.weight_ack) n_wh++;
      if (bus.input_loader_req && bus.input_loader_ack) begin
        n_ih++;
        ih_seq.push_back({oc_idx, ic_idx, h_idx});
      end
      if (prev_en && !bus.dataflow_en) beats_q.push_back(cur_beats);
      if (!prev_en && bus.dataflow_en) cur_beats = 0;
      if (bus.dataflow_en && (&bus.conv_vld)) cur_beats++;
      if (layer_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (last_layer_done) ld_both++;
      end
      if (last_layer_done) ld_cnt++;
    end
    prev_en = bus.dataflow_en;
  end

  task automatic start_layer(input int w, input int h, input int ic, input int oc,
                             input bit frame, input bit last);
    @(posedge clk);
    #1;
    cfg_w = CNT_W'(w); cfg_h = CNT_W'(h); cfg_ic = CNT_W'(ic); cfg_oc = CNT_W'(oc);
    cfg_frame = frame; is_last_layer = last;
    layer_start = 1'b1;
    @(posedge clk);
    #1;
    layer_start = 1'b0;
    // Scramble the config: only the values at the start pulse may matter.
    cfg_w = CNT_W'($urandom_range(0, 7)); cfg_h = CNT_W'($urandom_range(0, 7));
    cfg_ic = CNT_W'($urandom_range(0, 7)); cfg_oc = CNT_W'($urandom_range(0, 7));
    cfg_frame = 1'($urandom); is_last_layer = 1'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("done_seen", 64'(done_cnt != 0), 64'd1);
    repeat (3) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Reference: expected loop visits and counts computed from the layer shape.
  task automatic check_model(input string tag, input int w, input int h, input int ic,
                             input int oc, input bit frame, input bit ideal);
    int W = (w == 0) ? 1 : w;
    int H = (h == 0) ? 1 : h;
    int IC = (ic == 0) ? 1 : ic;
    int OC = (oc == 0) ? 1 : oc;
    int exp_ih = frame ? IC * OC : IC * OC * H;
    int exp_beats = frame ? W * H : W;
    logic [47:0] exp_seq[$];
    for (int o = 0; o < OC; o++)
      for (int i = 0; i < IC; i++)
        if (frame) exp_seq.push_back({16'(o), 16'(i), 16'd0});
        else for (int r = 0; r < H; r++) exp_seq.push_back({16'(o), 16'(i), 16'(r)});
    chk({tag, ".done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, ".weight_hs"}, 64'(n_wh), 64'(IC * OC));
    chk({tag, ".input_hs"}, 64'(n_ih), 64'(exp_ih));
    chk({tag, ".computes"}, 64'(beats_q.size()), 64'(exp_ih));
    for (int k = 0; k < beats_q.size(); k++)
      chk({tag, ".beats"}, 64'(beats_q[k]), 64'(exp_beats));
    for (int k = 0; k < exp_seq.size() && k < ih_seq.size(); k++)
      chk({tag, ".oc_ic_h"}, 64'(ih_seq[k]), 64'(exp_seq[k]));
    chk({tag, ".wsel"}, 64'(weight_buf_sel), 64'((IC * OC) % 2));
    chk({tag, ".isel"}, 64'(input_buff_sel), 64'(exp_ih % 2));
    chk({tag, ".oc_final"}, 64'(oc_idx), 64'(OC - 1));
    chk({tag, ".ic_final"}, 64'(ic_idx), 64'(IC - 1));
    if (!frame) chk({tag, ".h_final"}, 64'(h_idx), 64'(H - 1));
    chk({tag, ".busy_end"}, 64'(busy), 64'd0);
    if (ideal) chk({tag, ".done_cyc"}, 64'(done_cyc),
                   frame ? 64'(OC * IC * (W * H + 3) + 1) : 64'(OC * IC * (1 + H * (W + 2)) + 1));
  endtask

  initial begin
    #2 rstn = 1'b0;
    #1;
    chk("reset_outputs", {61'd0, bus.weight_req, bus.input_loader_req, bus.dataflow_en}, 64'd0);
    chk("reset_status", {59'd0, busy, layer_done, last_layer_done, weight_buf_sel,
                         input_buff_sel}, 64'd0);
    chk("reset_idx", {w_idx, h_idx, ic_idx, oc_idx}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // 1: row mode, single weight load, exact cycle timing.
    start_layer(2, 2, 1, 1, 1'b0, 1'b0);
    wait_done(200);
    chk("s1.wreq_cycles", wreq_mask, 64'h2);
    chk("s1.ireq_cycles", ireq_mask, 64'h44);
    chk("s1.en_cycles", en_mask, 64'h198);
    chk("s1.last_done", 64'(ld_cnt), 64'd0);
    check_model("s1", 2, 2, 1, 1, 1'b0, 1'b1);

    // 2: frame mode loop counts.
    start_layer(2, 3, 2, 2, 1'b1, 1'b0);
    wait_done(400);
    check_model("s2", 2, 3, 2, 2, 1'b1, 1'b1);

    // 3: weight back-pressure, then partial valid inside COMPUTE.
    auto_drv = 1'b0;
    bus.weight_ack = 1'b0; bus.input_loader_ack = 1'b1; bus.conv_vld = '0;
    start_layer(3, 1, 1, 1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("s3.wreq_hold", 64'(bus.weight_req), 64'd1);
      chk("s3.idx_hold", {w_idx, h_idx, ic_idx, oc_idx}, 64'd0);
      @(posedge clk);
      #1;
    end
    bus.weight_ack = 1'b1;
    @(negedge clk);
    chk("s3.wreq_at_ack", 64'(bus.weight_req), 64'd1);
    @(posedge clk);
    #1 bus.weight_ack = 1'b0;
    @(negedge clk);
    chk("s3.ireq", {62'd0, bus.weight_req, bus.input_loader_req}, 64'd1);
    @(posedge clk);
    #1 bus.conv_vld = 9'h1FE;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("s3.partial_en", 64'(bus.dataflow_en), 64'd1);
      chk("s3.partial_w", 64'(w_idx), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.conv_vld = '1;
    wait_done(100);
    chk("s3.wreq_hi_cycles", 64'(n_wreq_hi), 64'd6);
    check_model("s3", 3, 1, 1, 1, 1'b0, 1'b0);
    auto_drv = 1'b1;

    // 4: re-pulsed start is ignored; last-layer flag.
    start_layer(2, 2, 1, 1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    cfg_w = 16'd5; cfg_frame = 1'b1; layer_start = 1'b1;
    @(posedge clk);
    #1 layer_start = 1'b0;
    wait_done(200);
    chk("s4.wreq_cycles", wreq_mask, 64'h2);
    chk("s4.ireq_cycles", ireq_mask, 64'h44);
    chk("s4.en_cycles", en_mask, 64'h198);
    chk("s4.last_done", 64'(ld_cnt), 64'd1);
    chk("s4.last_with_done", 64'(ld_both), 64'd1);
    check_model("s4", 2, 2, 1, 1, 1'b0, 1'b1);

    // 5: zero config behaves as 1x1x1x1.
    start_layer(0, 0, 0, 0, 1'b0, 1'b0);
    wait_done(100);
    check_model("s5", 0, 0, 0, 0, 1'b0, 1'b1);

    // 6: reset during COMPUTE with oc_idx = 1, then a clean restart.
    start_layer(2, 1, 1, 2, 1'b0, 1'b0);
    begin
      int k = 0;
      while (!(oc_idx == 16'd1 && bus.dataflow_en) && k < 200) begin
        @(negedge clk);
        k++;
      end
      chk("s6.reached_oc1", 64'(oc_idx), 64'd1);
    end
    #2 rstn = 1'b0;
    #1;
    chk("s6.rst_bus", {61'd0, bus.weight_req, bus.input_loader_req, bus.dataflow_en}, 64'd0);
    chk("s6.rst_status", {59'd0, busy, layer_done, last_layer_done, weight_buf_sel,
                          input_buff_sel}, 64'd0);
    chk("s6.rst_idx", {w_idx, h_idx, ic_idx, oc_idx}, 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    start_layer(2, 2, 1, 1, 1'b0, 1'b0);
    wait_done(200);
    chk("s6.restart_en", en_mask, 64'h198);
    check_model("s6", 2, 2, 1, 1, 1'b0, 1'b1);

    // Randomised shapes, modes, ack delays and partial valids.
    for (int t = 0; t < 8; t++) begin
      int rw = $urandom_range(0, 3);
      int rh = $urandom_range(0, 3);
      int ric = $urandom_range(0, 3);
      int roc = $urandom_range(0, 3);
      bit rf = 1'($urandom);
      ack_rand = 1'($urandom);
      vld_rand = 1'($urandom);
      start_layer(rw, rh, ric, roc, rf, 1'b0);
      wait_done(5000);
      check_model("rnd", rw, rh, ric, roc, rf, !ack_rand && !vld_rand);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
